// File: rtl/io_timer.sv
// Memory-mapped prescaled timer with compare match and level interrupt.
// Read data is registered for its own window and chained combinationally otherwise.
module io_timer #(
  parameter logic [13:0] TBASE = 14'h3C00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        timer_irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  logic [2:0]  ctrl;
  logic [15:0] prescale;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;
  logic [15:0] pre_cnt;
  logic        hit_q;
  logic [31:0] rdata_q;

  logic [13:0] woff;
  logic [13:0] roff;
  logic        whit;
  logic        rhit;
  logic        wr_ctrl;
  logic        wr_prescale;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        en;
  logic        periodic;
  logic        irqen;
  logic        tick;
  logic [31:0] count_inc;
  logic        cmp_hit;
  logic        match_set;
  logic [31:0] read_val;

  // Offset subtraction keeps the window correct even for a non-8-aligned base.
  assign woff = dma_io_wadr - TBASE;
  assign roff = dma_io_radr - TBASE;
  assign whit = dma_io_we && (woff[13:3] == 11'd0);
  assign rhit = dma_io_radr_en && (roff[13:3] == 11'd0);

  assign wr_ctrl     = whit && (woff[2:0] == OFF_CTRL);
  assign wr_prescale = whit && (woff[2:0] == OFF_PRESCALE);
  assign wr_count    = whit && (woff[2:0] == OFF_COUNT);
  assign wr_compare  = whit && (woff[2:0] == OFF_COMPARE);
  assign wr_status   = whit && (woff[2:0] == OFF_STATUS);

  assign en       = ctrl[0];
  assign periodic = ctrl[1];
  assign irqen    = ctrl[2];

  assign tick      = en && (pre_cnt == prescale);
  assign count_inc = count + 32'd1;
  assign cmp_hit   = (count_inc == compare);
  // A COUNT write overrides the tick, so no match can be raised on that edge.
  assign match_set = tick && !wr_count && cmp_hit;

  assign timer_irq    = match && irqen;
  assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= 3'd0;
      prescale <= 16'd0;
      compare  <= 32'hFFFF_FFFF;
    end else begin
      if (wr_ctrl)     ctrl     <= dma_io_wdata[2:0];
      if (wr_prescale) prescale <= dma_io_wdata[15:0];
      if (wr_compare)  compare  <= dma_io_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 16'd0;
    end else if (wr_prescale || wr_count) begin
      pre_cnt <= 16'd0;
    end else if (en) begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (wr_count) begin
      count <= dma_io_wdata;
    end else if (tick) begin
      count <= (cmp_hit && periodic) ? 32'd0 : count_inc;
    end
  end

  // Set has priority over a software clear landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match <= 1'b0;
    end else if (match_set) begin
      match <= 1'b1;
    end else if (wr_status && dma_io_wdata[0]) begin
      match <= 1'b0;
    end
  end

  always_comb begin
    read_val = 32'd0;
    case (roff[2:0])
      OFF_CTRL:     read_val = {29'd0, ctrl};
      OFF_PRESCALE: read_val = {16'd0, prescale};
      OFF_COUNT:    read_val = count;
      OFF_COMPARE:  read_val = compare;
      OFF_STATUS:   read_val = {31'd0, match};
      default:      read_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      hit_q <= rhit;
      if (rhit) rdata_q <= read_val;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: register access table followed by timed
// sequences for prescaling, one-shot/periodic match, wrap and reset.
module tb_io_timer;

  localparam logic [13:0] TB = 14'h3C00;
  localparam logic [31:0] RIN = 32'hC0DE_0000;

  logic        clk;
  logic        rst_n;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;
  logic        timer_irq;

  int n_chk  = 0;
  int n_pass = 0;

  io_timer #(.TBASE(TB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dma_io_we(dma_io_we),
    .dma_io_wadr(dma_io_wadr),
    .dma_io_wdata(dma_io_wdata),
    .dma_io_radr(dma_io_radr),
    .dma_io_radr_en(dma_io_radr_en),
    .dma_io_rdata_in(dma_io_rdata_in),
    .dma_io_rdata(dma_io_rdata),
    .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [13:0] wadr;
    logic [31:0] wdata;
    logic        ren;
    logic [13:0] radr;
    logic [31:0] rin;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic step(input logic we, input logic [13:0] wadr, input logic [31:0] wdata,
                      input logic ren, input logic [13:0] radr, input logic [31:0] rin);
    dma_io_we       = we;
    dma_io_wadr     = wadr;
    dma_io_wdata    = wdata;
    dma_io_radr_en  = ren;
    dma_io_radr     = radr;
    dma_io_rdata_in = rin;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] a(input int off);
    return TB + 14'(off);
  endfunction

  task automatic wr(input int off, input logic [31:0] d);
    step(1'b1, a(off), d, 1'b0, TB, RIN);
  endtask

  task automatic rd(input int off);
    step(1'b0, TB, 32'd0, 1'b1, a(off), RIN);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, TB, 32'd0, 1'b0, TB, RIN);
  endtask

  initial begin
    rst_n = 1'b0;
    dma_io_we = 1'b0; dma_io_wadr = TB; dma_io_wdata = 32'd0;
    dma_io_radr_en = 1'b0; dma_io_radr = TB; dma_io_rdata_in = 32'hA5A5_0001;

    tbl[0]  = '{1'b0, TB,    32'h0,         1'b0, TB,            32'hA5A5_0001, 32'hA5A5_0001, 1'b0};
    tbl[1]  = '{1'b0, TB,    32'h0,         1'b1, a(3),          RIN,           32'hFFFF_FFFF, 1'b0};
    tbl[2]  = '{1'b0, TB,    32'h0,         1'b1, a(0),          RIN,           32'h0,         1'b0};
    tbl[3]  = '{1'b1, a(0),  32'hFFFF_FFF2, 1'b1, a(0),          RIN,           32'h0,         1'b0};
    tbl[4]  = '{1'b0, TB,    32'h0,         1'b1, a(0),          RIN,           32'h2,         1'b0};
    tbl[5]  = '{1'b1, a(1),  32'hABCD_1234, 1'b1, a(1),          RIN,           32'h0,         1'b0};
    tbl[6]  = '{1'b0, TB,    32'h0,         1'b1, a(1),          RIN,           32'h1234,      1'b0};
    tbl[7]  = '{1'b1, a(3),  32'h55,        1'b1, a(5),          RIN,           32'h0,         1'b0};
    tbl[8]  = '{1'b0, TB,    32'h0,         1'b1, a(3),          RIN,           32'h55,        1'b0};
    tbl[9]  = '{1'b1, a(2),  32'h100,       1'b1, a(2),          RIN,           32'h0,         1'b0};
    tbl[10] = '{1'b0, TB,    32'h0,         1'b1, a(2),          RIN,           32'h100,       1'b0};
    tbl[11] = '{1'b1, a(6),  32'hFFFF_FFFF, 1'b1, a(6),          RIN,           32'h0,         1'b0};
    tbl[12] = '{1'b0, TB,    32'h0,         1'b1, a(4),          RIN,           32'h0,         1'b0};
    tbl[13] = '{1'b0, TB,    32'h0,         1'b1, a(8),          32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[14] = '{1'b1, a(10), 32'hDEAD,      1'b1, TB - 14'd1,    32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    tbl[15] = '{1'b0, TB,    32'h0,         1'b1, a(2),          RIN,           32'h100,       1'b0};

    #12;
    check("reset_irq", {31'd0, timer_irq}, 32'd0);
    check("reset_passthru", dma_io_rdata, 32'hA5A5_0001);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].we, tbl[i].wadr, tbl[i].wdata, tbl[i].ren, tbl[i].radr, tbl[i].rin);
      check($sformatf("tbl%0d_rdata", i), dma_io_rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_irq", i), {31'd0, timer_irq}, {31'd0, tbl[i].exp_irq});
    end

    // Prescale 3: one tick every 4 cycles after the EN write edge.
    wr(1, 32'd3); wr(2, 32'd0); wr(0, 32'd1);
    idle(3);
    rd(2); check("pre_before_tick", dma_io_rdata, 32'd0);
    idle(16);
    rd(2); check("pre_count5", dma_io_rdata, 32'd5);
    wr(0, 32'd0);
    idle(10);
    rd(2); check("en0_hold", dma_io_rdata, 32'd5);

    // One-shot match at 10 with interrupt enabled.
    wr(1, 32'd0); wr(2, 32'd0); wr(3, 32'd10); wr(0, 32'd5);
    for (int k = 1; k <= 13; k++) begin
      rd(2);
      check($sformatf("oneshot_cnt%0d", k), dma_io_rdata, 32'(k - 1));
      check($sformatf("oneshot_irq%0d", k), {31'd0, timer_irq}, (k >= 10) ? 32'd1 : 32'd0);
    end
    rd(4); check("oneshot_status", dma_io_rdata, 32'd1);
    wr(4, 32'd1); check("oneshot_clr_irq", {31'd0, timer_irq}, 32'd0);
    wr(0, 32'd0);

    // Periodic with COMPARE=4: COUNT cycles 1,2,3,0.
    wr(2, 32'd0); wr(3, 32'd4); wr(0, 32'd3);
    for (int k = 1; k <= 9; k++) begin
      rd(2);
      check($sformatf("per_cnt%0d", k), dma_io_rdata, 32'((k - 1) % 4));
      check($sformatf("per_irq%0d", k), {31'd0, timer_irq}, 32'd0);
    end
    rd(4);        check("per_match_set", dma_io_rdata, 32'd1);
    wr(4, 32'd1);
    rd(4);        check("per_clr", dma_io_rdata, 32'd0);
    rd(4);        check("per_reset", dma_io_rdata, 32'd1);
    wr(4, 32'd1);
    rd(4);        check("per_clr2", dma_io_rdata, 32'd0);
    wr(4, 32'd1);
    rd(4);        check("race_set_wins", dma_io_rdata, 32'd1);
    wr(0, 32'd0);

    // Wrap through zero, then a COUNT write on the tick that would match.
    wr(4, 32'd1); wr(3, 32'd5); wr(1, 32'd0); wr(2, 32'hFFFF_FFFE); wr(0, 32'd1);
    rd(2); check("wrap_fe", dma_io_rdata, 32'hFFFF_FFFE);
    rd(2); check("wrap_ff", dma_io_rdata, 32'hFFFF_FFFF);
    rd(2); check("wrap_0",  dma_io_rdata, 32'd0);
    rd(2); check("wrap_1",  dma_io_rdata, 32'd1);
    rd(4); check("wrap_nomatch", dma_io_rdata, 32'd0);
    idle(1);
    wr(2, 32'd7);
    rd(2); check("collide_cnt", dma_io_rdata, 32'd7);
    rd(4); check("collide_nomatch", dma_io_rdata, 32'd0);
    wr(0, 32'd0);

    // Asynchronous reset while running with the interrupt asserted.
    wr(2, 32'd0); wr(3, 32'd2); wr(0, 32'd5);
    idle(2);
    check("pre_rst_irq", {31'd0, timer_irq}, 32'd1);
    rd(0); check("pre_rst_ctrl", dma_io_rdata, 32'd5);
    dma_io_rdata_in = 32'h5A5A_0F0F;
    #2 rst_n = 1'b0;
    #1;
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    check("rst_passthru", dma_io_rdata, 32'h5A5A_0F0F);
    #2 rst_n = 1'b1;
    rd(0); check("post_rst_ctrl", dma_io_rdata, 32'd0);
    rd(2); check("post_rst_cnt", dma_io_rdata, 32'd0);
    rd(3); check("post_rst_cmp", dma_io_rdata, 32'hFFFF_FFFF);
    rd(2); check("post_rst_hold", dma_io_rdata, 32'd0);
    rd(4); check("post_rst_status", dma_io_rdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
